apb_master_arb: RTL and testbench

APB master-side arbiter and transfer sequencer for the DES block's register bus. Up to four internal requesters (e.g. the test-bench driver and the DMA/key-loader path) share one APB master port. The block grants them round-robin and drives the two-phase SETUP/ACCESS protocol onto the bus, including pready wait states. Each requester sees a simple req/ack handshake with read data returned on completion.

---
 rtl/apb_master_arb_pkg.sv | 13 +
 rtl/apb_master_arb_rr_pick.sv | 25 ++
 rtl/apb_master_arb.sv | 144 ++++++++++++++
 tb/tb_apb_master_arb.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_arb_pkg.sv
// Shared types and default bus widths for the APB master arbiter.
package apb_master_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/apb_master_arb_rr_pick.sv
// Combinational round-robin picker: first eligible requester after ptr, as a one-hot vector.
module apb_rr_pick #(
   parameter int N  = 2,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  mask,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  win
);

   logic [N-1:0] elig;

   always_comb begin
      elig = req & ~mask;
      win  = '0;
      // Walk from the farthest candidate to the nearest so the nearest one overwrites.
      for (int k = N; k >= 1; k--) begin
         if (elig[(int'(ptr) + k) % N]) begin
            win = N'(1) << ((int'(ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/apb_master_arb.sv
// Round-robin APB master: arbitrates up to four requesters and runs SETUP/ACCESS with wait states.
// Optional ACCESS timeout compiled in with APB_MASTER_ARB_TIMEOUT_EN.
module apb_master_arb
   import apb_master_arb_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ-1:0]          wr,
   input  logic [NUM_REQ*ADDR_W-1:0]   addr,
   input  logic [NUM_REQ*DATA_W-1:0]   wdata,
   output logic [NUM_REQ-1:0]          ack,
   output logic [DATA_W-1:0]           rdata,
   output logic                        err,
   output logic [NUM_REQ-1:0]          gnt,
   output logic                        psel,
   output logic                        penable,
   output logic                        pwrite,
   output logic [ADDR_W-1:0]           paddr,
   output logic [DATA_W-1:0]           pwdata,
   input  logic [DATA_W-1:0]           prdata,
   input  logic                        pready
);

   localparam int PW = $clog2(NUM_REQ);

   state_t              state, state_nxt;
   logic [PW-1:0]       ptr;
   logic [NUM_REQ-1:0]  win;
   logic [PW-1:0]       win_idx;
   logic                done;
   logic                tmo;

   // The acked requester is masked so it cannot be regranted before it drops req.
   apb_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
      .req  (req),
      .mask (ack),
      .ptr  (ptr),
      .win  (win)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win[i]) win_idx = PW'(i);
      end
   end

`ifdef APB_MASTER_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wcnt;
   logic          err_q;
   assign err = err_q;
`else
   // No timeout logic; err stays low for any legal limit.
   assign err = (TIMEOUT_CYCLES < 1);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      tmo       = 1'b0;
      psel      = 1'b0;
      penable   = 1'b0;
      case (state)
         IDLE: begin
            if (|win) state_nxt = SETUP;
         end
         SETUP: begin
            psel      = 1'b1;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            if (pready) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
`ifdef APB_MASTER_ARB_TIMEOUT_EN
            else if (int'(wcnt) + 1 >= TIMEOUT_CYCLES) begin
               tmo       = 1'b1;
               state_nxt = IDLE;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr    <= PW'(NUM_REQ - 1);
         gnt    <= '0;
         ack    <= '0;
         rdata  <= '0;
         pwrite <= 1'b0;
         paddr  <= '0;
         pwdata <= '0;
`ifdef APB_MASTER_ARB_TIMEOUT_EN
         wcnt   <= '0;
         err_q  <= 1'b0;
`endif
      end else begin
         ack   <= '0;
         rdata <= '0;
`ifdef APB_MASTER_ARB_TIMEOUT_EN
         err_q <= 1'b0;
         if (state == SETUP)                 wcnt <= '0;
         else if (state == ACCESS && !pready) wcnt <= wcnt + 1'b1;
`endif
         if (state == IDLE && |win) begin
            gnt    <= win;
            ptr    <= win_idx;
            pwrite <= wr[win_idx];
            paddr  <= addr[win_idx*ADDR_W +: ADDR_W];
            pwdata <= wdata[win_idx*DATA_W +: DATA_W];
         end
         if (done) begin
            ack <= gnt;
            gnt <= '0;
            if (!pwrite) rdata <= prdata;
         end
`ifdef APB_MASTER_ARB_TIMEOUT_EN
         if (tmo) begin
            ack   <= gnt;
            gnt   <= '0;
            err_q <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench with a completion scoreboard for apb_master_arb.
module tb_apb_master_arb;

   localparam int N   = 2;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req, wr, ack, gnt;
   logic [N*AW-1:0]   addr;
   logic [N*DW-1:0]   wdata;
   logic [DW-1:0]     rdata, pwdata, prdata;
   logic [AW-1:0]     paddr;
   logic              err, psel, penable, pwrite, pready;

   typedef struct {
      logic [N-1:0]  ack;
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total  = 0;
   int   passed = 0;
   int   fails  = 0;
   int   wait_n = 0;
   int   acc_k  = 0;

   apb_master_arb #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
      .ack(ack), .rdata(rdata), .err(err), .gnt(gnt),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .prdata(prdata), .pready(pready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_ack(input int budget, input string tag);
      bit got = 1'b0;
      for (int c = 0; c < budget && !got; c++) begin
         step();
         got = |ack;
      end
      chk(tag, 64'(got), 64'd1);
   endtask

   // Slave model: ACCESS cycle k (1-based) is ready once k exceeds wait_n.
   always @(negedge clk) begin
      if (psel && penable) acc_k = acc_k + 1;
      else                 acc_k = 0;
      pready = psel && penable && (acc_k > wait_n);
   end

   always @(negedge clk) begin
      if (!rst && |ack) begin
         if (sb.size() == 0) begin
            chk("unexpected_ack", 64'(ack), 64'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_ack", 64'(ack), 64'(mon_e.ack));
            chk("sb_rdata", 64'(rdata), 64'(mon_e.rdata));
            chk("sb_err", 64'(err), 64'(mon_e.err));
         end
      end
   end

   initial begin
      int n;
      bit any_ack, held;
      rst = 1'b1; req = '0; wr = '0; addr = '0; wdata = '0; prdata = '0; pready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_psel", 64'(psel), 0);
      chk("rst_penable", 64'(penable), 0);
      chk("rst_pwrite", 64'(pwrite), 0);
      chk("rst_paddr", 64'(paddr), 0);
      chk("rst_pwdata", 64'(pwdata), 0);
      chk("rst_rdata", 64'(rdata), 0);
      chk("rst_ack_gnt_err", {ack, gnt, err}, 0);
      rst = 1'b0;
      step();

      // Single zero-wait write from requester 0.
      wait_n = 0;
      req = 2'b01; wr = 2'b01; addr[0 +: AW] = 32'h10; wdata[0 +: DW] = 32'hDEADBEEF;
      sb.push_back('{ack: 2'b01, rdata: '0, err: 1'b0});
      step();
      chk("wr_c1_psel_pen", {psel, penable}, 2'b10);
      chk("wr_c1_gnt", 64'(gnt), 64'b01);
      chk("wr_c1_bus", {pwrite, paddr, pwdata}, {1'b1, 32'h10, 32'hDEADBEEF});
      step();
      chk("wr_c2_psel_pen", {psel, penable}, 2'b11);
      step();
      chk("wr_c3_ack", 64'(ack), 64'b01);
      chk("wr_c3_idle", {psel, penable, gnt}, 0);
      req = '0;
      step();

      // Read from requester 1 with three wait states.
      wait_n = 3; prdata = 32'h12345678;
      req = 2'b10; wr = 2'b00; addr[AW +: AW] = 32'h14;
      sb.push_back('{ack: 2'b10, rdata: 32'h12345678, err: 1'b0});
      for (int c = 1; c <= 6; c++) begin
         step();
         chk($sformatf("rd_ack_c%0d", c), 64'(ack), (c == 6) ? 64'b10 : 64'b00);
         if (c == 3) chk("rd_paddr", 64'(paddr), 64'h14);
      end
      chk("rd_rdata", 64'(rdata), 64'h12345678);
      req = '0;
      step();

      // Contention: both held, expect grant order 0,1,0,1.
      wait_n = 0;
      req = 2'b11; wr = 2'b11; addr[0 +: AW] = 32'h20; addr[AW +: AW] = 32'h24;
      for (int i = 0; i < 4; i++) sb.push_back('{ack: (i % 2 == 0) ? 2'b01 : 2'b10, rdata: '0, err: 1'b0});
      n = 0;
      for (int c = 0; c < 60 && n < 4; c++) begin
         step();
         chk("rr_onehot", 64'($countones(gnt) <= 1), 64'd1);
         if (|ack) begin
            n++;
            if (n == 4) req = '0;
         end
      end
      chk("rr_count", 64'(n), 64'd4);
      step();

      // Reset during ACCESS, then first grant goes to requester 0.
      wait_n = 100000;
      req = 2'b10; wr = 2'b00;
      step(); step();
      chk("rst_mid_access", {psel, penable}, 2'b11);
      rst = 1'b1;
      #1;
      chk("rst_async_bus", {psel, penable, gnt, ack}, 0);
      @(negedge clk);
      rst = 1'b0; wait_n = 0; prdata = 32'hA5A5_0001;
      req = 2'b11; wr = 2'b00;
      sb.push_back('{ack: 2'b01, rdata: 32'hA5A5_0001, err: 1'b0});
      step();
      chk("rst_first_gnt", 64'(gnt), 64'b01);
      wait_n = 0;
      wait_ack(20, "rst_ack_seen");
      req = '0;
      step();

`ifdef APB_MASTER_ARB_TIMEOUT_EN
      wait_n = 100000; prdata = 32'hFFFF_FFFF;
      req = 2'b01; wr = 2'b00;
      sb.push_back('{ack: 2'b01, rdata: '0, err: 1'b1});
      for (int c = 1; c <= 6; c++) begin
         step();
         chk($sformatf("tmo_ack_c%0d", c), 64'(ack), (c == 6) ? 64'b01 : 64'b00);
      end
      chk("tmo_err", 64'(err), 64'd1);
      req = '0;
      step();
      chk("tmo_bus_idle", {psel, penable}, 2'b00);
`else
      wait_n = 100000; prdata = 32'hFFFF_FFFF;
      req = 2'b01; wr = 2'b00;
      step(); step();
      any_ack = 1'b0; held = 1'b1;
      for (int c = 0; c < 100; c++) begin
         step();
         any_ack |= |ack;
         held &= psel & penable;
      end
      chk("stuck_no_ack", 64'(any_ack), 64'd0);
      chk("stuck_bus_held", 64'(held), 64'd1);
      chk("stuck_err", 64'(err), 64'd0);
      req = '0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      step();
`endif

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
